// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared widths, FSM state type and step-width helper for seq_normalizer
package shifter_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int STEP_W = 3;

  localparam logic [STEP_W-1:0] STEP_FIRST = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] step_width(input logic [STEP_W-1:0] s);
    return CNT_W'(1) << s;
  endfunction

endpackage

// File: rtl/seq_normalizer_norm_step.sv
// rtl/seq_normalizer_norm_step.sv - one normalization step: shift by 2^step when the top bits are redundant
module norm_step
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0] value_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] value_o,
  output logic              hit_o
);

  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] top_u;
  logic [DATA_W-1:0] top_s;
  logic [DATA_W-1:0] ones;

  // Signed mode inspects w+1 bits so the sign bit survives the shift.
  always_comb begin
    w       = DATA_W'(1) << step_i;
    top_u   = value_i >> (DATA_W - w);
    top_s   = value_i >> (DATA_W - 1 - w);
    ones    = (DATA_W'(2) << w) - DATA_W'(1);
    hit_o   = signed_i ? ((top_s == '0) || (top_s == ones)) : (top_u == '0);
    value_o = hit_o ? (value_i << w) : value_i;
  end

endmodule

// File: rtl/seq_normalizer.sv
// rtl/seq_normalizer.sv - sequential normalizer, fixed 5-cycle latency, valid/ready handshakes
// Signed (redundant sign bit) mode is built only when NORM_SIGNED_EN is defined.
module seq_normalizer
  import shifter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic [CNT_W-1:0]  count,
  output logic              zero
);

  state_e            state_q;
  logic [DATA_W-1:0] work_q;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] step_value;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  acc_d;
  logic [CNT_W-1:0]  count_q;
  logic [STEP_W-1:0] step_q;
  logic              mode_q;
  logic              mode_eff;
  logic              step_hit;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              zero_q;

`ifdef NORM_SIGNED_EN
  assign mode_eff = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = 1'b0;
`endif

  norm_step u_step (
    .value_i  (work_q),
    .step_i   (step_q),
    .signed_i (mode_q),
    .value_o  (step_value),
    .hit_o    (step_hit)
  );

  assign acc_d = acc_q + (step_hit ? step_width(step_q) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      work_q      <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      mode_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in;
            mode_q     <= mode_eff;
            acc_q      <= '0;
            step_q     <= STEP_FIRST;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= step_value;
          acc_q  <= acc_d;
          if (step_q == '0) begin
            out_q       <= step_value;
            // Shifts are lossless, so a zero result means a zero operand.
            zero_q      <= (step_value == '0);
            count_q     <= (!mode_q && step_value == '0) ? CNT_W'(DATA_W) : acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            step_q <= step_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign count     = count_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// tb/tb_seq_normalizer.sv - self-checking bench for seq_normalizer (directed + randomized vs. model)
module tb_seq_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  count;
  logic        zero;

  int tests = 0;
  int fails = 0;

  seq_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data),
    .count     (count),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: count leading zeros (unsigned) or redundant sign bits (signed, capped at 31).
  function automatic void ref_norm(input logic [31:0] x, input logic m,
                                   output logic [31:0] o, output logic [5:0] c, output logic z);
    int  n;
    logic sm;
`ifdef NORM_SIGNED_EN
    sm = m;
`else
    sm = 1'b0;
`endif
    n = 0;
    if (!sm) begin
      while (n < 32 && x[31-n] == 1'b0) n++;
    end else begin
      while (n < 31 && x[30-n] == x[31]) n++;
    end
    o = (n >= 32) ? 32'd0 : (x << n);
    c = 6'(n);
    z = (x == 32'd0);
  endfunction

  task automatic run_op(input string name, input logic [31:0] x, input logic m,
                        input logic [31:0] eo, input logic [5:0] ec, input logic ez,
                        input int hold, input bit noise);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s in_ready_before_accept act=%b exp=1", name, in_ready);
    end
    in_valid = 1'b1;
    in_data  = x;
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        in_data  = $urandom;
        mode     = 1'($urandom);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== (k == 5)) begin
        fails++;
        $display("FAIL %s latency edge%0d out_valid act=%b exp=%b", name, k, out_valid, (k == 5));
      end
    end
    in_valid = 1'b0;
    tests++;
    if (out_data !== eo || count !== ec || zero !== ez) begin
      fails++;
      $display("FAIL %s result x=%h mode=%b act out=%h count=%0d zero=%b exp out=%h count=%0d zero=%b",
               name, x, m, out_data, count, zero, eo, ec, ez);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== eo || count !== ec || zero !== ez) begin
        fails++;
        $display("FAIL %s hold%0d act valid=%b ready=%b out=%h count=%0d zero=%b exp valid=1 ready=0 out=%h count=%0d zero=%b",
                 name, h, out_valid, in_ready, out_data, count, zero, eo, ec, ez);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s release act valid=%b ready=%b exp valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 || count !== 6'd0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state act ready=%b valid=%b out=%h count=%0d zero=%b exp ready=1 valid=0 out=0 count=0 zero=0",
               in_ready, out_valid, out_data, count, zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("u_one",   32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0, 0, 1'b0);
    run_op("u_zero",  32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1, 0, 1'b0);
    run_op("u_msb",   32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0, 0, 1'b0);
    run_op("u_f0",    32'h00F0_0000, 1'b0, 32'hF000_0000, 6'd8,  1'b0, 0, 1'b0);
`ifdef NORM_SIGNED_EN
    run_op("s_zero",  32'h0000_0000, 1'b1, 32'h0000_0000, 6'd31, 1'b1, 0, 1'b0);
    run_op("s_ones",  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 6'd31, 1'b0, 0, 1'b0);
    run_op("s_ffff",  32'hFFFF_0000, 1'b1, 32'h8000_0000, 6'd15, 1'b0, 0, 1'b0);
    run_op("s_12345", 32'h0001_2345, 1'b1, 32'h48D1_4000, 6'd14, 1'b0, 0, 1'b0);
    run_op("s_norm",  32'h4000_0001, 1'b1, 32'h4000_0001, 6'd0,  1'b0, 0, 1'b0);
`else
    run_op("m_zero",  32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1, 0, 1'b0);
    run_op("m_ffff",  32'hFFFF_0000, 1'b1, 32'hFFFF_0000, 6'd0,  1'b0, 0, 1'b0);
    run_op("m_12345", 32'h0001_2345, 1'b1, 32'h91A2_8000, 6'd15, 1'b0, 0, 1'b0);
`endif
  endtask

  task automatic test_hold();
    run_op("hold3", 32'h0000_0F00, 1'b0, 32'hF000_0000, 6'd20, 1'b0, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 32'h0000_0003;
    mode     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 6'd0) begin
      fails++;
      $display("FAIL reset_mid act ready=%b valid=%b count=%0d exp ready=1 valid=0 count=0",
               in_ready, out_valid, count);
    end
    repeat (6) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_no_result act valid=%b exp valid=0", out_valid);
      end
    end
    run_op("after_rst", 32'h00F0_0000, 1'b0, 32'hF000_0000, 6'd8, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] x, eo;
    logic [5:0]  ec;
    logic        ez, m;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       x = 32'd0;
        1:       x = 32'hFFFF_FFFF;
        default: x = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 1) == 1) x = ~x;
      m = 1'($urandom);
      ref_norm(x, m, eo, ec, ez);
      run_op("rand", x, m, eo, ec, ez, $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, eo;
    logic [5:0]  ec;
    logic        ez;
    for (int i = 0; i < 4; i++) begin
      x = 32'h1 << (i * 9);
      ref_norm(x, 1'b0, eo, ec, ez);
      run_op("b2b", x, 1'b0, eo, ec, ez, 0, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    mode      = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from package constants (DATA_W=32, CNT_W=6).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand offered.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in  input  32  operand to normalize.
REQ-007 mode  input  1  0 = unsigned (count leading zeros), 1 = signed (count redundant sign bits); sampled with the operand.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out  output  32  operand shifted left by count (logical, zero fill).
REQ-011 count  output  6  left-shift amount applied, 0..32.
REQ-012 zero  output  1  operand was all zeros.

Function
REQ-013 FSM SHALL have states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE and out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid & in_ready, the block SHALL capture in into a working register, latch mode, clear count, set the step index to 4, and go to SHIFT.
REQ-015 SHIFT: each cycle, with w = 2^step, unsigned mode SHALL shift the working register left by w and add w to count when its top w bits are all 0; signed mode SHALL do so when bits [31:31-w] all equal bit 31.
REQ-016 SHIFT SHALL run exactly 5 cycles (step 4,3,2,1,0), then go to DONE; latency SHALL be fixed: out_valid high after the 5th rising edge following the accept edge.
REQ-017 Unsigned mode, all-zero working register after step 0: count SHALL be forced to 32 when entering DONE; out SHALL be 0.
REQ-018 Signed mode: count SHALL saturate at 31 (input 0 -> out 0, count 31; input 0xFFFFFFFF -> out 0x80000000, count 31).
REQ-019 zero SHALL be 1 in DONE iff the captured operand was 0, in either mode.
REQ-020 DONE: out, count, zero SHALL hold stable while out_ready is 0; on out_ready = 1 the block SHALL return to IDLE at that edge.
REQ-021 No new operand SHALL be accepted in SHIFT or DONE; in_valid asserted there SHALL be ignored without side effects.
REQ-022 Operand 0x80000000 (unsigned) or an already-normalized signed operand SHALL still take the full 5 SHIFT cycles and produce count 0, out unchanged.

Reset
REQ-023 While rst is 1 at a rising edge: state SHALL become IDLE, in_ready SHALL be 1, out_valid 0, out 0, count 0, zero 0.
REQ-024 Reset during SHIFT or DONE SHALL discard the operation in progress with no result delivered.

Configuration
REQ-025 Macro NORM_SIGNED_EN: when defined, signed mode SHALL operate per REQ-015/REQ-018.
REQ-026 When NORM_SIGNED_EN is undefined, the mode port SHALL remain but be ignored and all operands SHALL be treated as unsigned.

Structure
REQ-027 Package shifter_pkg SHALL hold DATA_W, CNT_W and the FSM state enum (IDLE, SHIFT, DONE).
REQ-028 One combinational sub-module norm_step SHALL implement a single step (inputs: value, step index, mode; outputs: shifted value, hit flag), instantiated once and reused across the 5 SHIFT cycles.

Verification
REQ-029 Unsigned 0x00000001 -> out 0x80000000, count 31, zero 0, out_valid 5 edges after accept.
REQ-030 Unsigned 0x00000000 -> out 0, count 32, zero 1; signed 0x00000000 -> out 0, count 31, zero 1.
REQ-031 Signed 0xFFFF0000 -> out 0x80000000, count 15; signed 0x00012345 -> out 0x48D14000, count 14.
REQ-032 Result in DONE with out_ready low for 3 cycles -> out/count held, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE, in_ready 1 next cycle.
REQ-033 rst asserted on the 3rd SHIFT cycle -> next cycle IDLE, out_valid 0, count 0; following operand 0x00F00000 unsigned -> count 8, out 0xF0000000.
